cmd_line_sequencer: RTL and testbench

//  - Sequences one SD CMD-line transaction: loads a 48-bit command into the parallel_serial converter and waits for it to finish.
//  - Optionally hunts for the card's response start bit, runs serial_parallel and validates the captured 48-bit response.
//  - Sits between the host command register and the two CMD-path converters; it is the only driver of their enable/reset pins.

---
 rtl/cmd_line_sequencer_pkg.sv | 20 ++
 rtl/cmd_line_sequencer_crc7.sv | 22 ++
 rtl/cmd_line_sequencer.sv | 155 +++++++++++++++
 tb/tb_cmd_line_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_line_sequencer_pkg.sv
// Shared CMD-path definitions: frame geometry, start/dir/end bit values, CRC7 polynomial and sequencer states.
package cmd_line_sequencer_pkg;

  localparam int           CMD_FRAME_BITS = 48;
  localparam logic         CMD_START_BIT  = 1'b0;
  localparam logic         CMD_DIR_CARD   = 1'b0;
  localparam logic         CMD_END_BIT    = 1'b1;
  localparam logic [6:0]   CRC7_POLY      = 7'h09;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    RECEIVE   = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6
  } seqState_t;

endpackage

// File: rtl/cmd_line_sequencer_crc7.sv
// cmd_crc7: serial CRC7 (x^7+x^3+1) LFSR, one bit per enabled clock, MSB-first data.
module cmd_crc7
  import cmd_line_sequencer_pkg::*;
(
  input  logic       iClock_SD,
  input  logic       iReset,
  input  logic       iClear,
  input  logic       iEnable,
  input  logic       iBit,
  output logic [6:0] oCrc
);

  logic fb;
  assign fb = iBit ^ oCrc[6];

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset)       oCrc <= '0;
    else if (iClear)  oCrc <= '0;
    else if (iEnable) oCrc <= {oCrc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
  end

endmodule

// File: rtl/cmd_line_sequencer.sv
// Sequences one SD CMD-line transaction (send, optional response capture and check).
// Define CMD_CRC7_EN to add the serial CRC7 check of the captured response.
module cmd_line_sequencer
  import cmd_line_sequencer_pkg::*;
#(
  parameter int FRAME_BITS = CMD_FRAME_BITS,
  parameter int NCR_MAX    = 64,
  parameter int CNT_W      = 7
)(
  input  logic                  iClock_SD,
  input  logic                  iReset,
  input  logic                  iStart,
  input  logic [FRAME_BITS-1:0] iCommand,
  input  logic                  iExpect_response,
  input  logic                  iCmd_line,
  output logic                  oPs_reset,
  output logic                  oPs_enable,
  output logic [FRAME_BITS-1:0] oPs_parallel,
  input  logic                  iPs_complete,
  output logic                  oSp_reset,
  output logic                  oSp_enable,
  input  logic                  iSp_complete,
  input  logic [FRAME_BITS-1:0] iSp_parallel,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [FRAME_BITS-1:0] oResponse,
  output logic                  oTimeout,
  output logic                  oFrame_error,
  output logic                  oCrc_error
);

  seqState_t        state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             expectResp;
  logic             accept, cntClr, cntInc, setTimeout, capResp;

`ifdef CMD_CRC7_EN
  localparam int CRC_BITS = FRAME_BITS - 8;
  localparam int IDX_W    = $clog2(FRAME_BITS);
  logic [6:0]       crcVal;
  logic [IDX_W-1:0] crcIdx;
  logic             crcEn, crcClr, crcBit, crcFin;
`endif

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    cntClr     = 1'b0;
    cntInc     = 1'b0;
    setTimeout = 1'b0;
    capResp    = 1'b0;
    case (state)
      IDLE: if (iStart) begin
        accept    = 1'b1;
        stateNext = LOAD;
      end
      LOAD: stateNext = SEND;
      SEND: if (iPs_complete) begin
        cntClr    = 1'b1;
        stateNext = expectResp ? WAIT_RESP : DONE;
      end
      // A start bit seen on the last count takes priority over the timeout.
      WAIT_RESP: begin
        if (!iCmd_line) stateNext = RECEIVE;
        else if (cnt == CNT_W'(NCR_MAX - 1)) begin
          setTimeout = 1'b1;
          stateNext  = DONE;
        end else cntInc = 1'b1;
      end
      RECEIVE: if (iSp_complete) begin
        capResp   = 1'b1;
        cntClr    = 1'b1;
        stateNext = CHECK;
      end
`ifdef CMD_CRC7_EN
      CHECK: begin
        if (cnt == CNT_W'(CRC_BITS)) stateNext = DONE;
        else cntInc = 1'b1;
      end
`else
      CHECK: stateNext = DONE;
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Converter controls are decoded straight from state so reset forces them immediately.
  assign oPs_reset  = !(state == LOAD || state == SEND);
  assign oPs_enable = (state == SEND);
  assign oSp_reset  = !(state == WAIT_RESP || state == RECEIVE);
  assign oSp_enable = (state == RECEIVE) || (state == WAIT_RESP && !iCmd_line);
  assign oBusy      = (state != IDLE);
  assign oDone      = (state == DONE);

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) begin
      cnt          <= '0;
      expectResp   <= 1'b0;
      oPs_parallel <= '0;
      oResponse    <= '0;
      oTimeout     <= 1'b0;
      oFrame_error <= 1'b0;
    end else begin
      if (cntClr)                cnt <= '0;
      else if (cntInc && cnt != '1) cnt <= cnt + 1'b1;
      if (accept) begin
        expectResp   <= iExpect_response;
        oPs_parallel <= iCommand;
        oResponse    <= '0;
        oTimeout     <= 1'b0;
        oFrame_error <= 1'b0;
      end
      if (setTimeout) oTimeout <= 1'b1;
      if (capResp) begin
        oResponse    <= iSp_parallel;
        oFrame_error <= (iSp_parallel[FRAME_BITS-1] != CMD_START_BIT) ||
                        (iSp_parallel[FRAME_BITS-2] != CMD_DIR_CARD)  ||
                        (iSp_parallel[0]            != CMD_END_BIT);
      end
    end
  end

`ifdef CMD_CRC7_EN
  // Walk oResponse[47:8] MSB first using the shared counter as bit index.
  assign crcIdx = IDX_W'(FRAME_BITS - 1) - IDX_W'(cnt);
  assign crcBit = oResponse[crcIdx];
  assign crcEn  = (state == CHECK) && (cnt != CNT_W'(CRC_BITS));
  assign crcClr = (state != CHECK);
  assign crcFin = (state == CHECK) && (cnt == CNT_W'(CRC_BITS));

  cmd_crc7 uCrc (
    .iClock_SD (iClock_SD),
    .iReset    (iReset),
    .iClear    (crcClr),
    .iEnable   (crcEn),
    .iBit      (crcBit),
    .oCrc      (crcVal)
  );

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset)                               oCrc_error <= 1'b0;
    else if (accept)                          oCrc_error <= 1'b0;
    else if (crcFin && crcVal != oResponse[7:1]) oCrc_error <= 1'b1;
  end
`else
  assign oCrc_error = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_line_sequencer.sv
// Directed bench for cmd_line_sequencer; bench drives the converter handshakes by hand.
module tb_cmd_line_sequencer;

  localparam int NCR_MAX = 64;
  localparam logic [47:0] CMD0 = 48'h400000000095;
  localparam logic [47:0] CMD8 = 48'h48000001AA87;

  logic        clk = 1'b0;
  logic        iReset, iStart, iExpect, iCmdLine, iPsComplete, iSpComplete;
  logic [47:0] iCommand, iSpParallel;
  logic        oPsReset, oPsEnable, oSpReset, oSpEnable, oBusy, oDone;
  logic        oTimeout, oFrameError, oCrcError;
  logic [47:0] oPsParallel, oResponse;

  int vecs = 0;
  int errs = 0;
  logic spSeen;

  always #5 clk = ~clk;

  cmd_line_sequencer #(.FRAME_BITS(48), .NCR_MAX(NCR_MAX), .CNT_W(7)) dut (
    .iClock_SD(clk), .iReset(iReset), .iStart(iStart), .iCommand(iCommand),
    .iExpect_response(iExpect), .iCmd_line(iCmdLine),
    .oPs_reset(oPsReset), .oPs_enable(oPsEnable), .oPs_parallel(oPsParallel),
    .iPs_complete(iPsComplete), .oSp_reset(oSpReset), .oSp_enable(oSpEnable),
    .iSp_complete(iSpComplete), .iSp_parallel(iSpParallel),
    .oBusy(oBusy), .oDone(oDone), .oResponse(oResponse), .oTimeout(oTimeout),
    .oFrame_error(oFrameError), .oCrc_error(oCrcError)
  );

  always @(negedge clk) if (oSpEnable === 1'b1) spSeen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    logic fb;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mkResp(input logic [39:0] p);
    return {p, crc7(p), 1'b1};
  endfunction

  // Ends on the negedge where the sequencer sits in LOAD.
  task automatic startCmd(input logic [47:0] cmd, input logic exp);
    @(negedge clk);
    iStart = 1'b1; iCommand = cmd; iExpect = exp;
    @(negedge clk);
    iStart = 1'b0; iCommand = 48'hDEADBEEF0123; iExpect = ~exp;
    chk("busy after start", oBusy, 1);
    chk("ps frame latched", oPsParallel, cmd);
    chk("ps reset in load", oPsReset, 0);
    chk("ps enable in load", oPsEnable, 0);
    chk("flags cleared", {oTimeout, oFrameError, oCrcError}, 0);
  endtask

  // Completes the send on SEND cycle n; ends one negedge later.
  task automatic sendPhase(input int n);
    repeat (n) @(negedge clk);
    chk("ps enable in send", oPsEnable, 1);
    iPsComplete = 1'b1;
    @(negedge clk);
    iPsComplete = 1'b0;
    chk("ps reset after send", oPsReset, 1);
    chk("ps enable after send", oPsEnable, 0);
  endtask

  // Called on WAIT_RESP cycle 1; start bit on cycle dly, complete after 48 shifted bits.
  task automatic rxPhase(input int dly, input logic [47:0] resp, input bit glitch);
    repeat (dly - 1) @(negedge clk);
    chk("sp reset in wait", oSpReset, 0);
    iCmdLine = 1'b0;
    #1 chk("sp enable on start bit", oSpEnable, 1);
    for (int r = 1; r <= 47; r++) begin
      @(negedge clk);
      iCmdLine = resp[47 - r];
      if (glitch && r == 5) begin iStart = 1'b1; iCommand = 48'h123456789ABC; end
      if (glitch && r == 6) iStart = 1'b0;
      if (r == 47) begin
        chk("sp enable in receive", oSpEnable, 1);
        iSpParallel = resp; iSpComplete = 1'b1;
      end
    end
    @(negedge clk);
    iSpComplete = 1'b0; iCmdLine = 1'b1; iSpParallel = 48'hA5A5A5A5A5A5;
    chk("sp reset after receive", oSpReset, 1);
    chk("sp enable after receive", oSpEnable, 0);
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (oDone !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done reached", oDone, 1);
  endtask

  task automatic finishTxn();
    @(negedge clk);
    chk("done is one pulse", oDone, 0);
    chk("busy drops after done", oBusy, 0);
  endtask

  task automatic runCmd0();
    spSeen = 1'b0;
    startCmd(CMD0, 1'b0);
    sendPhase(48);
    chk("cmd0 done 1clk after complete", oDone, 1);
    chk("cmd0 busy during done", oBusy, 1);
    finishTxn();
    chk("cmd0 flags", {oTimeout, oFrameError, oCrcError}, 0);
    chk("cmd0 sp enable never", spSeen, 0);
  endtask

  logic [47:0] r2, rBad;
  int n, extra;

  initial begin
    r2 = mkResp(40'h08000001AA);
    iReset = 1'b1; iStart = 1'b0; iExpect = 1'b0; iCmdLine = 1'b1;
    iPsComplete = 1'b0; iSpComplete = 1'b0; iCommand = '0; iSpParallel = '0;
    repeat (3) @(negedge clk);
    chk("rst ps reset", oPsReset, 1);
    chk("rst sp reset", oSpReset, 1);
    chk("rst enables", {oPsEnable, oSpEnable}, 0);
    chk("rst busy done", {oBusy, oDone}, 0);
    chk("rst ps frame", oPsParallel, 0);
    chk("rst response", oResponse, 0);
    chk("rst flags", {oTimeout, oFrameError, oCrcError}, 0);
    iReset = 1'b0;

    // CMD0, no response
    runCmd0();

    // CMD8 with R7 response, start bit 10 clocks after send completes
    startCmd(CMD8, 1'b1);
    sendPhase(6);
    rxPhase(10, r2, 1'b0);
    waitDone(n);
    chk("cmd8 response", oResponse, r2);
    chk("cmd8 flags", {oTimeout, oFrameError, oCrcError}, 0);
    finishTxn();
    chk("cmd8 response held", oResponse, r2);

    // timeout: line stays high
    startCmd(CMD8, 1'b1);
    sendPhase(3);
    waitDone(n);
    chk("timeout latency", n, NCR_MAX);
    chk("timeout flag", oTimeout, 1);
    finishTxn();
    chk("timeout held", oTimeout, 1);

    // start bit on the final count beats the timeout
    startCmd(CMD8, 1'b1);
    sendPhase(2);
    rxPhase(NCR_MAX, r2, 1'b0);
    waitDone(n);
    chk("last-count no timeout", oTimeout, 0);
    chk("last-count response", oResponse, r2);
    finishTxn();

    // end bit cleared -> frame error
    rBad = r2 & ~48'h1;
    startCmd(CMD8, 1'b1);
    sendPhase(4);
    rxPhase(3, rBad, 1'b0);
    waitDone(n);
    chk("frame err flag", oFrameError, 1);
    chk("frame err crc", oCrcError, 0);
    finishTxn();

    // payload bit flipped -> CRC error only when the checker is built
    rBad = r2 ^ (48'h1 << 20);
    startCmd(CMD8, 1'b1);
    sendPhase(4);
    rxPhase(3, rBad, 1'b0);
    waitDone(n);
    chk("crc flip frame", oFrameError, 0);
`ifdef CMD_CRC7_EN
    chk("crc flip crc err", oCrcError, 1);
`else
    chk("crc flip crc tied", oCrcError, 0);
`endif
    finishTxn();

    // async reset in the middle of SEND
    startCmd(CMD0, 1'b0);
    repeat (10) @(negedge clk);
    #2 iReset = 1'b1;
    #1;
    chk("midsend rst ps reset", oPsReset, 1);
    chk("midsend rst ps enable", oPsEnable, 0);
    chk("midsend rst busy", oBusy, 0);
    chk("midsend rst ps frame", oPsParallel, 0);
    chk("midsend rst response", oResponse, 0);
    chk("midsend rst flags", {oTimeout, oFrameError, oCrcError}, 0);
    @(negedge clk);
    iReset = 1'b0;
    runCmd0();

    // iStart during RECEIVE is ignored
    startCmd(CMD8, 1'b1);
    sendPhase(4);
    rxPhase(2, r2, 1'b1);
    waitDone(n);
    chk("glitch response", oResponse, r2);
    chk("glitch flags", {oTimeout, oFrameError, oCrcError}, 0);
    chk("glitch ps frame kept", oPsParallel, CMD8);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (oDone === 1'b1 || oBusy === 1'b1) extra++;
    end
    chk("glitch single done", extra, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
